// File: rtl/amp_state_control_mc.sv
// amp_state_control_mc: per-amplifier power/mute sequencer with a shared
// round-robin config-bus arbiter, nerror debounce, timed retry and lockout.
module amp_state_control_mc #(
    parameter int unsigned N_AMP       = 2,
    parameter int unsigned CW          = 20,
    parameter int unsigned T_PWRUP     = 1000,
    parameter int unsigned T_UNMUTE    = 500,
    parameter int unsigned T_MUTE      = 100,
    parameter int unsigned T_RETRY     = 20000,
    parameter int unsigned CFG_TIMEOUT = 4096,
    parameter int unsigned ERR_DEB     = 4,
    parameter int unsigned MAX_RETRY   = 3,
    localparam int unsigned CHW        = (N_AMP > 1) ? $clog2(N_AMP) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             audio_locked,
    input  logic [N_AMP-1:0] nerror,
    input  logic             cfg_done,
    input  logic             fault_clr,
    output logic [N_AMP-1:0] nenable,
    output logic [N_AMP-1:0] nmute,
    output logic             send_config,
    output logic [CHW-1:0]   cfg_ch,
    output logic [N_AMP-1:0] fault,
    output logic [N_AMP-1:0] lockout
);

    localparam int unsigned DW = $clog2(ERR_DEB + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_OFF, S_POWERUP, S_CONFIG, S_UNMUTE, S_RUN, S_MUTEDN, S_FAULT, S_LOCKOUT
    } state_t;

    state_t          st_q   [N_AMP];
    state_t          st_nx  [N_AMP];
    logic [CW-1:0]   tmr_q  [N_AMP];
    logic [CW-1:0]   tmr_nx [N_AMP];
    logic [DW-1:0]   deb_q  [N_AMP];
    logic [DW-1:0]   deb_nx [N_AMP];
    logic [RW-1:0]   rty_q  [N_AMP];
    logic [RW-1:0]   rty_nx [N_AMP];

    logic [N_AMP-1:0] req;
    logic [N_AMP-1:0] nen_nx, nm_nx, flt_nx, lko_nx;

    logic             busy_q, busy_nx;
    logic [CW-1:0]    atmr_q, atmr_nx;
    logic [CHW-1:0]   rr_q, rr_nx, ch_nx;
    logic             send_nx;

    // Per-channel next state; lock loss beats fault beats timer/config events.
    always_comb begin
        logic own, active, timed, hit, to_fault;
        for (int i = 0; i < N_AMP; i++) begin
            own      = busy_q && (cfg_ch == CHW'(i));
            active   = (st_q[i] == S_POWERUP) || (st_q[i] == S_CONFIG) ||
                       (st_q[i] == S_UNMUTE)  || (st_q[i] == S_RUN);
            timed    = (st_q[i] == S_POWERUP) || (st_q[i] == S_UNMUTE) ||
                       (st_q[i] == S_MUTEDN)  || (st_q[i] == S_FAULT);
            hit      = active && !nerror[i] && (deb_q[i] == DW'(ERR_DEB - 1));
            to_fault = 1'b0;
            st_nx[i] = st_q[i];
            deb_nx[i] = (active && !nerror[i]) ? deb_q[i] + DW'(1) : '0;

            case (st_q[i])
                S_OFF:     if (audio_locked) st_nx[i] = S_POWERUP;
                S_POWERUP: begin
                    if (!audio_locked)                        st_nx[i] = S_OFF;
                    else if (hit)                             to_fault = 1'b1;
                    else if (tmr_q[i] == CW'(T_PWRUP - 1))    st_nx[i] = S_CONFIG;
                end
                S_CONFIG: begin
                    if (!audio_locked)                        st_nx[i] = S_OFF;
                    else if (hit)                             to_fault = 1'b1;
                    else if (own && cfg_done)                 st_nx[i] = S_UNMUTE;
                    else if (own && (atmr_q == CW'(CFG_TIMEOUT - 1)))
                                                              st_nx[i] = S_FAULT;
                end
                S_UNMUTE: begin
                    if (!audio_locked)                        st_nx[i] = S_MUTEDN;
                    else if (hit)                             to_fault = 1'b1;
                    else if (tmr_q[i] == CW'(T_UNMUTE - 1))   st_nx[i] = S_RUN;
                end
                S_RUN: begin
                    if (!audio_locked)                        st_nx[i] = S_MUTEDN;
                    else if (hit)                             to_fault = 1'b1;
                end
                S_MUTEDN:  if (tmr_q[i] == CW'(T_MUTE - 1))   st_nx[i] = S_OFF;
                S_FAULT:   if (tmr_q[i] == CW'(T_RETRY - 1))  st_nx[i] = S_OFF;
                S_LOCKOUT: if (fault_clr || !audio_locked)    st_nx[i] = S_OFF;
                default:                                      st_nx[i] = S_OFF;
            endcase

            if (to_fault)
                st_nx[i] = (rty_q[i] == RW'(MAX_RETRY)) ? S_LOCKOUT : S_FAULT;

            // Retry count: saturating increment on FAULT entry, cleared on lock loss or fault_clr.
            rty_nx[i] = rty_q[i];
            if ((st_nx[i] == S_FAULT) && (st_q[i] != S_FAULT) && (rty_q[i] != RW'(MAX_RETRY)))
                rty_nx[i] = rty_q[i] + RW'(1);
            if (!audio_locked || fault_clr)
                rty_nx[i] = '0;

            tmr_nx[i] = ((st_nx[i] != st_q[i]) || !timed) ? '0 : tmr_q[i] + CW'(1);

            req[i]    = (st_nx[i] == S_CONFIG);
            nen_nx[i] = (st_nx[i] == S_OFF) || (st_nx[i] == S_FAULT) || (st_nx[i] == S_LOCKOUT);
            nm_nx[i]  = (st_nx[i] == S_RUN);
            flt_nx[i] = (st_nx[i] == S_FAULT) || (st_nx[i] == S_LOCKOUT);
            lko_nx[i] = (st_nx[i] == S_LOCKOUT);
        end
    end

    // Round-robin config arbiter; requests are channels entering/staying in CONFIG.
    always_comb begin
        logic           found;
        logic [CHW-1:0] idx;
        busy_nx = busy_q;
        ch_nx   = cfg_ch;
        atmr_nx = atmr_q;
        rr_nx   = rr_q;
        send_nx = 1'b0;
        found   = 1'b0;
        idx     = '0;
        if (busy_q) begin
            if (cfg_done || (atmr_q == CW'(CFG_TIMEOUT - 1))) begin
                busy_nx = 1'b0;
                rr_nx   = (int'(cfg_ch) == int'(N_AMP) - 1) ? '0 : cfg_ch + CHW'(1);
            end else begin
                atmr_nx = atmr_q + CW'(1);
            end
        end else begin
            for (int k = 0; k < N_AMP; k++) begin
                idx = CHW'((int'(rr_q) + k) % int'(N_AMP));
                if (!found && req[idx]) begin
                    found = 1'b1;
                    ch_nx = idx;
                end
            end
            if (found) begin
                busy_nx = 1'b1;
                atmr_nx = '0;
                send_nx = 1'b1;
            end
        end
    end

    // State, timers and registered outputs; reset forces nmute low asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_AMP; i++) begin
                st_q[i]  <= S_OFF;
                tmr_q[i] <= '0;
                deb_q[i] <= '0;
                rty_q[i] <= '0;
            end
            nenable     <= '1;
            nmute       <= '0;
            fault       <= '0;
            lockout     <= '0;
            send_config <= 1'b0;
            cfg_ch      <= '0;
            busy_q      <= 1'b0;
            atmr_q      <= '0;
            rr_q        <= '0;
        end else begin
            st_q        <= st_nx;
            tmr_q       <= tmr_nx;
            deb_q       <= deb_nx;
            rty_q       <= rty_nx;
            nenable     <= nen_nx;
            nmute       <= nm_nx;
            fault       <= flt_nx;
            lockout     <= lko_nx;
            send_config <= send_nx;
            cfg_ch      <= ch_nx;
            busy_q      <= busy_nx;
            atmr_q      <= atmr_nx;
            rr_q        <= rr_nx;
        end
    end

endmodule
